address_arbiter_mux: RTL
========================

Name: address_arbiter_mux

Overview:
Parametrised successor of the 2:1 address multiplexer. It takes NUM_CH request channels, each with its own address, and arbitrates between them round-robin. The winning address goes into a single registered output stage with a valid/ready handshake. It sits between the fetch, load/store and DMA address sources and the shared memory address port.

Parameters:
ADDR_WIDTH, 11, width of every address bus.
NUM_CH, 4, number of request channels; legal range 2..16.
SEL_WIDTH, clog2(NUM_CH), width of the channel index; derived, never overridden.

Ports:
CLK  input  1  single clock, rising edge.
RST_N  input  1  reset; synchronous, active-low.
IREQ  input  NUM_CH  per-channel request; bit i belongs to channel i.
IADDR  input  NUM_CH*ADDR_WIDTH  flattened channel addresses; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
IGNT  output  NUM_CH  one-hot grant; channel's address is captured this cycle.
OVALID  output  1  OADDR/OSEL hold a valid transfer.
OREADY  input  1  downstream accepts the transfer.
OADDR  output  ADDR_WIDTH  registered selected address.
OSEL  output  SEL_WIDTH  registered index of the channel that owns OADDR.

Behaviour:
- Reset (RST_N=0 at a rising CLK edge):
  - OVALID=0, OADDR=0, OSEL=0.
  - Round-robin pointer LAST=NUM_CH-1, so channel 0 has top priority first.
  - IGNT forced to 0 while RST_N=0.
  - Reset mid-operation discards any pending output; no grant is reissued.
- LOAD = (|IREQ) && (!OVALID || OREADY).
- Winner: first requesting channel searching upward from LAST+1, wrapping modulo NUM_CH.
- IGNT[winner]=1 combinationally only when LOAD=1; all other bits 0. IGNT is never multi-hot.
- On a LOAD edge: OADDR<=IADDR[winner], OSEL<=winner, OVALID<=1, LAST<=winner.
- Latency: address appears on OADDR one cycle after its grant cycle.
- Throughput: one transfer per cycle while OREADY=1.
- OVALID && !OREADY: OADDR/OSEL/OVALID hold stable, IGNT=0, LAST unchanged (backpressure).
- OVALID && OREADY && IREQ=0: OVALID<=0; OADDR/OSEL keep their last value.
- Simultaneous OREADY and a new request: accept and reload in the same edge; no bubble.
- Channel protocol: hold IREQ and IADDR stable until IGNT. Deasserting IREQ before grant is legal (request withdrawn). IADDR is sampled only in the grant cycle.
- Single requester: granted every load opportunity regardless of LAST.
- Fairness: with all channels requesting and OREADY=1, grants cycle 0,1,...,NUM_CH-1,0.
- No X propagation: OADDR only ever loads from the selected channel.

Optional Feature:
Macro ADDR_MUX_LOCK_EN.
- Defined:
  - Adds input ILOCK, width NUM_CH.
  - If the channel in OSEL has ILOCK[OSEL]=1 and IREQ[OSEL]=1 at a load opportunity, it wins over round-robin order.
  - Lock releases when that channel drops ILOCK or IREQ; arbitration resumes from LAST.
  - Used for atomic read-modify-write address pairs.
- Undefined: no ILOCK port; pure round-robin.

Decomposition:
- Shared package addr_mux_pkg:
  - default ADDR_WIDTH;
  - clog2 helper function;
  - channel-index constants CH_FETCH=0, CH_LSU=1, CH_DMA=2, CH_DBG=3.
- One sub-module, rr_arbiter:
  - combinational winner pick from IREQ, LAST and (optionally) the lock override;
  - outputs one-hot and encoded winner.
- address_arbiter_mux owns the LAST register, the output register stage and the handshake.

Test Plan:
1. Reset check: RST_N=0 for 2 cycles with IREQ=4'b1111 -> IGNT=0, OVALID=0, OADDR=0. First post-reset grant -> IGNT=4'b0001.
2. Round-robin fairness: IREQ=4'b1111, OREADY=1, IADDR ch i = 11'h100+i -> IGNT sequence 0001,0010,0100,1000,0001. OADDR one cycle later is 100,101,102,103; OSEL is 0,1,2,3.
3. Backpressure: ch2 requests with addr 11'h2AA, OREADY=0 for 3 cycles -> OVALID=1 and OADDR=2AA held, IGNT=0 while stalled. OREADY=1 then accepts it, and ch1 (addr 11'h155) is granted in the same edge.
4. Wrap and skip: LAST=3, IREQ=4'b0100 -> ch2 granted. Next IREQ=4'b0011 -> ch0 granted before ch1.
5. Empty drain: single transfer accepted with OREADY=1, then IREQ=0 -> OVALID falls next cycle, OADDR retains its value.
6. With ADDR_MUX_LOCK_EN: ch1 holds ILOCK=1 and IREQ=1 while IREQ=4'b1111 -> ch1 granted on 3 consecutive loads. ILOCK drops -> next grant is ch2.

Source files
------------

// File: rtl/addr_mux_pkg.sv
// Shared constants and helpers for the round-robin address arbiter/mux.
package addr_mux_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 11;

  localparam int unsigned CH_FETCH = 0;
  localparam int unsigned CH_LSU   = 1;
  localparam int unsigned CH_DMA   = 2;
  localparam int unsigned CH_DBG   = 3;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner pick with optional lock override.
// The lock override is only driven when ADDR_MUX_LOCK_EN is defined in the top.
module rr_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]    req_i,
  input  logic [SEL_WIDTH-1:0] last_i,
  input  logic                 lock_i,
  input  logic [SEL_WIDTH-1:0] lock_sel_i,
  output logic [NUM_CH-1:0]    gnt_oh_o,
  output logic [SEL_WIDTH-1:0] gnt_idx_o
);

  logic                 found;
  logic [SEL_WIDTH-1:0] cand;

  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    // Search upward from last+1; offset NUM_CH lands back on last itself.
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = SEL_WIDTH'((32'(last_i) + off) % NUM_CH);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (lock_i) begin
      gnt_idx_o = lock_sel_i;
    end
    gnt_oh_o            = '0;
    gnt_oh_o[gnt_idx_o] = |req_i;
  end

endmodule

// File: rtl/address_arbiter_mux.sv
// Round-robin N-channel address arbiter feeding a registered valid/ready output stage.
// Define ADDR_MUX_LOCK_EN to add the ILOCK port (sticky grant for atomic sequences).
module address_arbiter_mux
  import addr_mux_pkg::*;
#(
  parameter int unsigned  ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned  NUM_CH     = 4,
  localparam int unsigned SEL_WIDTH  = clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NUM_CH-1:0]            IREQ,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] IADDR,
`ifdef ADDR_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]            ILOCK,
`endif
  output logic [NUM_CH-1:0]            IGNT,
  output logic                         OVALID,
  input  logic                         OREADY,
  output logic [ADDR_WIDTH-1:0]        OADDR,
  output logic [SEL_WIDTH-1:0]         OSEL
);

  logic [NUM_CH-1:0]     gnt_oh;
  logic [SEL_WIDTH-1:0]  gnt_idx;
  logic                  lock_active;
  logic                  load;
  logic [ADDR_WIDTH-1:0] addr_sel;

  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [SEL_WIDTH-1:0]  last_q, last_d;

`ifdef ADDR_MUX_LOCK_EN
  assign lock_active = ILOCK[sel_q] & IREQ[sel_q];
`else
  assign lock_active = 1'b0;
`endif

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_rr_arbiter (
    .req_i     (IREQ),
    .last_i    (last_q),
    .lock_i    (lock_active),
    .lock_sel_i(sel_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx)
  );

  assign load = (|IREQ) && (!valid_q || OREADY);
  assign IGNT = (load && RST_N) ? gnt_oh : '0;

  // Explicit compare-mux so only the selected channel can reach OADDR.
  always_comb begin
    addr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (gnt_idx == SEL_WIDTH'(i)) begin
        addr_sel = IADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_sel;
      sel_d   = gnt_idx;
      last_d  = gnt_idx;
    end else if (OREADY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      last_q  <= SEL_WIDTH'(NUM_CH - 1);
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign OVALID = valid_q;
  assign OADDR  = addr_q;
  assign OSEL   = sel_q;

endmodule
